// File: rtl/uart_fifo_bridge.sv
// ---------------------------------------------------------------------------
// uart_fifo_bridge
//
// Buffered bridge between the tiny1 memory-mapped UART ports and the buart
// serial core. Received bytes are queued in an RX FIFO so the CPU can poll
// late. CPU writes are queued in a TX FIFO so the CPU never waits on busy.
//
// Handshakes:
//   CPU RX side : cpu_valid_o = RX not empty. cpu_din_o is the RX head
//                 (first-word-fall-through, 0 when empty). cpu_rd_i pops the
//                 head at the clock edge; a pop while empty is ignored.
//   CPU TX side : cpu_ready_o = TX not full. cpu_wr_i pushes cpu_dout_i at the
//                 clock edge; a push while full is ignored and the byte lost.
//   buart RX    : u_valid_i is level and stays high until acknowledged.
//                 u_rd_o is a one-cycle registered acknowledge.
//   buart TX    : u_wr_o is a one-cycle registered strobe qualifying
//                 u_tx_data_o. It is only issued while u_busy_i is low.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   cpu_din_o         RX head byte
//   cpu_valid_o       RX FIFO not empty
//   cpu_rd_i          pop RX head
//   cpu_ready_o       TX FIFO not full
//   cpu_wr_i          push cpu_dout_i into TX FIFO
//   cpu_dout_i        byte to transmit
//   ovr_clr_i         clear sticky overrun flag
//   rx_overrun_o      sticky: a received byte was dropped (RX full)
//   rx_count_o        RX occupancy, 0..2**DEPTH_LOG2
//   u_rx_data_i       buart receive byte
//   u_valid_i         buart has a byte
//   u_rd_o            acknowledge to buart
//   u_busy_i          buart transmitter busy
//   u_tx_data_o       byte to buart
//   u_wr_o            transmit strobe to buart
//   dbg_rx_state_o    RX state machine state (0 = RX_IDLE, 1 = RX_ACK)
//   dbg_tx_state_o    TX state machine state (0 = TX_IDLE, 1 = TX_HOLD)
// ---------------------------------------------------------------------------
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [7:0]            cpu_din_o,
    output logic                  cpu_valid_o,
    input  logic                  cpu_rd_i,
    output logic                  cpu_ready_o,
    input  logic                  cpu_wr_i,
    input  logic [7:0]            cpu_dout_i,
    input  logic                  ovr_clr_i,
    output logic                  rx_overrun_o,
    output logic [DEPTH_LOG2:0]   rx_count_o,
    input  logic [7:0]            u_rx_data_i,
    input  logic                  u_valid_i,
    output logic                  u_rd_o,
    input  logic                  u_busy_i,
    output logic [7:0]            u_tx_data_o,
    output logic                  u_wr_o,
    output logic                  dbg_rx_state_o,
    output logic                  dbg_tx_state_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_t;

    // -----------------------------------------------------------------------
    // RX FIFO
    // -----------------------------------------------------------------------
    logic [7:0]            rx_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
    rx_state_t             rx_state_q;
    logic                  u_rd_q;
    logic                  rx_overrun_q;

    logic rx_full, rx_empty, rx_take, rx_push, rx_drop, rx_pop;

    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    // A byte is taken (acknowledged) whenever the FSM is idle and buart offers
    // one; whether it is stored or dropped depends only on RX occupancy.
    assign rx_take  = (rx_state_q == RX_IDLE) && u_valid_i;
    assign rx_push  = rx_take && !rx_full;
    assign rx_drop  = rx_take && rx_full;
    assign rx_pop   = cpu_rd_i && !rx_empty;

    always_comb begin
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;
        if (rx_push) begin
            rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
        end
        if (rx_pop) begin
            rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
        end
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // Storage carries no reset: stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= u_rx_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
        end else begin
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
        end
    end

    // RX state machine. RX_ACK absorbs the cycle u_valid_i needs to fall
    // after the acknowledge, so one byte is never taken twice.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            u_rd_q     <= 1'b0;
        end else begin
            u_rd_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (u_valid_i) begin
                        u_rd_q     <= 1'b1;
                        rx_state_q <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    rx_state_q <= RX_IDLE;
                end
                default: begin
                    rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_overrun_q <= 1'b0;
        end else if (rx_drop) begin
            rx_overrun_q <= 1'b1;
        end else if (ovr_clr_i) begin
            rx_overrun_q <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // TX FIFO
    // -----------------------------------------------------------------------
    logic [7:0]            tx_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [DEPTH_LOG2-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;
    tx_state_t             tx_state_q;
    logic                  u_wr_q;
    logic [7:0]            u_tx_data_q;

    logic tx_full, tx_empty, tx_push, tx_launch;

    assign tx_full   = (tx_cnt_q == FULL_CNT);
    assign tx_empty  = (tx_cnt_q == '0);
    assign tx_push   = cpu_wr_i && !tx_full;
    // Launching a byte to buart is the TX FIFO pop.
    assign tx_launch = (tx_state_q == TX_IDLE) && !tx_empty && !u_busy_i;

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        if (tx_push) begin
            tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
        end
        if (tx_launch) begin
            tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
        end
        case ({tx_push, tx_launch})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= cpu_dout_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

    // TX state machine. TX_HOLD covers the cycle buart takes to raise busy
    // after a strobe, so strobes are always at least two cycles apart.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q  <= TX_IDLE;
            u_wr_q      <= 1'b0;
            u_tx_data_q <= 8'h00;
        end else begin
            u_wr_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_launch) begin
                        u_wr_q      <= 1'b1;
                        u_tx_data_q <= tx_mem_q[tx_rd_ptr_q];
                        tx_state_q  <= TX_HOLD;
                    end
                end
                TX_HOLD: begin
                    tx_state_q <= TX_IDLE;
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cpu_din_o      = rx_empty ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
    assign cpu_valid_o    = !rx_empty;
    assign cpu_ready_o    = !tx_full;
    assign rx_count_o     = rx_cnt_q;
    assign rx_overrun_o   = rx_overrun_q;
    assign u_rd_o         = u_rd_q;
    assign u_wr_o         = u_wr_q;
    assign u_tx_data_o    = u_tx_data_q;
    assign dbg_rx_state_o = rx_state_q;
    assign dbg_tx_state_o = tx_state_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo_bridge
//
// Directed bench for uart_fifo_bridge (DEPTH_LOG2 = 4). Inputs are driven and
// outputs sampled 1 ns after each rising edge. A buart model on the falling
// edge raises u_busy for busy_len cycles after every u_wr strobe (or holds it
// high while force_busy is set) and checks transmitted bytes against exp_q.
// ---------------------------------------------------------------------------
module tb_uart_fifo_bridge;

    logic       clk;
    logic       rst;
    logic [7:0] cpu_din;
    logic       cpu_valid;
    logic       cpu_rd;
    logic       cpu_ready;
    logic       cpu_wr;
    logic [7:0] cpu_dout;
    logic       ovr_clr;
    logic       rx_overrun;
    logic [4:0] rx_count;
    logic [7:0] u_rx_data;
    logic       u_valid;
    logic       u_rd;
    logic       u_busy;
    logic [7:0] u_tx_data;
    logic       u_wr;
    logic       dbg_rx_state;
    logic       dbg_tx_state;

    uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_din_o      (cpu_din),
        .cpu_valid_o    (cpu_valid),
        .cpu_rd_i       (cpu_rd),
        .cpu_ready_o    (cpu_ready),
        .cpu_wr_i       (cpu_wr),
        .cpu_dout_i     (cpu_dout),
        .ovr_clr_i      (ovr_clr),
        .rx_overrun_o   (rx_overrun),
        .rx_count_o     (rx_count),
        .u_rx_data_i    (u_rx_data),
        .u_valid_i      (u_valid),
        .u_rd_o         (u_rd),
        .u_busy_i       (u_busy),
        .u_tx_data_o    (u_tx_data),
        .u_wr_o         (u_wr),
        .dbg_rx_state_o (dbg_rx_state),
        .dbg_tx_state_o (dbg_tx_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];
    int  tx_seen      = 0;
    int  rd_pulses    = 0;
    int  busy_viol    = 0;
    int  spacing_viol = 0;
    int  busy_left    = 0;
    int  busy_len     = 10;
    logic force_busy  = 1'b0;
    logic busy_prev   = 1'b0;
    logic wr_prev     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- buart model / monitor ----------------
    always @(posedge clk) busy_prev = u_busy;

    always @(negedge clk) begin
        if (u_rd) rd_pulses++;
        if (u_wr) begin
            tx_seen++;
            if (busy_prev) busy_viol++;
            if (wr_prev) spacing_viol++;
            if (exp_q.size() == 0) begin
                check("tx_unexpected_strobe", 32'(1), 32'(0));
            end else begin
                check("tx_data", 32'(u_tx_data), 32'(exp_q.pop_front()));
            end
            busy_left = busy_len;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        wr_prev = u_wr;
        u_busy  = force_busy || (busy_left > 0);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte as buart would; returns edges waited for the acknowledge.
    task automatic rx_send(input logic [7:0] b, output int lat);
        lat       = 0;
        u_rx_data = b;
        u_valid   = 1'b1;
        do begin
            tick();
            lat++;
        end while (!u_rd && lat < 8);
        if (!u_rd) check("rx_ack_timeout", 32'(0), 32'(1));
        u_valid = 1'b0;
        tick();
    endtask

    task automatic cpu_pop();
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic cpu_push(input logic [7:0] b);
        cpu_wr   = 1'b1;
        cpu_dout = b;
        tick();
        cpu_wr   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int base;
        logic ready_low;

        rst = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_dout = 8'h00;
        ovr_clr = 1'b0; u_rx_data = 8'h00; u_valid = 1'b0; u_busy = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_cpu_valid", 32'(cpu_valid), 32'(0));
        check("rst_cpu_ready", 32'(cpu_ready), 32'(1));
        check("rst_u_rd", 32'(u_rd), 32'(0));
        check("rst_u_wr", 32'(u_wr), 32'(0));
        check("rst_overrun", 32'(rx_overrun), 32'(0));
        check("rst_rx_count", 32'(rx_count), 32'(0));
        check("rst_cpu_din", 32'(cpu_din), 32'(0));
        rst = 1'b1;
        tick();

        // RX single byte
        rd_pulses = 0;
        u_rx_data = 8'h41;
        u_valid   = 1'b1;
        tick();
        check("rx1_u_rd_latency", 32'(u_rd), 32'(1));
        check("rx1_valid_same_cycle", 32'(cpu_valid), 32'(1));
        check("rx1_din_same_cycle", 32'(cpu_din), 32'h41);
        u_valid = 1'b0;
        tick();
        tick();
        check("rx1_rd_pulses", 32'(rd_pulses), 32'(1));
        check("rx1_count", 32'(rx_count), 32'(1));
        check("rx1_din", 32'(cpu_din), 32'h41);
        cpu_pop();
        check("rx1_pop_valid", 32'(cpu_valid), 32'(0));
        check("rx1_pop_count", 32'(rx_count), 32'(0));
        check("rx1_pop_din", 32'(cpu_din), 32'(0));

        // RX overflow: 17 bytes, 0x10 dropped
        for (int i = 0; i <= 16; i++) rx_send(8'(i), lat);
        check("ovf_count", 32'(rx_count), 32'(16));
        check("ovf_valid", 32'(cpu_valid), 32'(1));
        check("ovf_overrun", 32'(rx_overrun), 32'(1));
        for (int i = 0; i < 16; i++) begin
            check("ovf_pop_order", 32'(cpu_din), 32'(i));
            cpu_pop();
        end
        check("ovf_drained_valid", 32'(cpu_valid), 32'(0));
        check("ovf_overrun_sticky", 32'(rx_overrun), 32'(1));
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovf_clr", 32'(rx_overrun), 32'(0));

        // RX push/pop across wrap: pointers are at 1, move them to 15
        for (int i = 0; i < 14; i++) begin
            rx_send(8'h20 + 8'(i), lat);
            cpu_pop();
        end
        rx_send(8'hA0, lat);
        rx_send(8'hA1, lat);
        rx_send(8'hA2, lat);
        check("wrap_count_pre", 32'(rx_count), 32'(3));
        check("wrap_head_pre", 32'(cpu_din), 32'hA0);
        u_rx_data = 8'hA3;
        u_valid   = 1'b1;
        cpu_rd    = 1'b1;
        tick();
        cpu_rd    = 1'b0;
        check("wrap_simul_ack", 32'(u_rd), 32'(1));
        check("wrap_simul_count", 32'(rx_count), 32'(3));
        check("wrap_simul_head", 32'(cpu_din), 32'hA1);
        u_valid = 1'b0;
        tick();
        cpu_pop();
        check("wrap_order_2", 32'(cpu_din), 32'hA2);
        cpu_pop();
        check("wrap_order_3", 32'(cpu_din), 32'hA3);
        cpu_pop();
        check("wrap_empty", 32'(cpu_valid), 32'(0));

        // TX burst with busy held 10 cycles after each strobe
        busy_len = 10;
        base     = tx_seen;
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h49);
        cpu_wr   = 1'b1;
        cpu_dout = 8'h48;
        tick();
        check("txb_ready_1", 32'(cpu_ready), 32'(1));
        check("txb_no_strobe_yet", 32'(u_wr), 32'(0));
        cpu_dout = 8'h49;
        tick();
        cpu_wr = 1'b0;
        check("txb_latency", 32'(u_wr), 32'(1));
        check("txb_ready_2", 32'(cpu_ready), 32'(1));
        ready_low = 1'b0;
        for (int i = 0; i < 60 && tx_seen < base + 2; i++) begin
            tick();
            if (!cpu_ready) ready_low = 1'b1;
        end
        tick();
        check("txb_strobes", 32'(tx_seen - base), 32'(2));
        check("txb_ready_held", 32'(ready_low), 32'(0));
        repeat (15) tick();

        // TX full while busy
        force_busy = 1'b1;
        tick();
        base = tx_seen;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'h60 + 8'(i));
            cpu_push(8'h60 + 8'(i));
            if (i == 14) check("txf_ready_15", 32'(cpu_ready), 32'(1));
            if (i == 15) check("txf_full_16", 32'(cpu_ready), 32'(0));
        end
        check("txf_full_17", 32'(cpu_ready), 32'(0));
        check("txf_none_while_busy", 32'(tx_seen - base), 32'(0));
        force_busy = 1'b0;
        for (int i = 0; i < 400 && tx_seen < base + 16; i++) tick();
        repeat (30) tick();
        check("txf_strobes", 32'(tx_seen - base), 32'(16));
        check("txf_queue_empty", 32'(exp_q.size()), 32'(0));
        check("txf_ready_after", 32'(cpu_ready), 32'(1));

        // Reset mid-operation: RX 5 bytes, TX 3 bytes held by busy
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) rx_send(8'hC0 + 8'(i), lat);
        for (int i = 0; i < 3; i++) cpu_push(8'hD0 + 8'(i));
        check("mrst_rx_pre", 32'(rx_count), 32'(5));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mrst_valid", 32'(cpu_valid), 32'(0));
        check("mrst_ready", 32'(cpu_ready), 32'(1));
        check("mrst_count", 32'(rx_count), 32'(0));
        check("mrst_din", 32'(cpu_din), 32'(0));
        base       = tx_seen;
        force_busy = 1'b0;
        repeat (40) tick();
        check("mrst_no_tx", 32'(tx_seen - base), 32'(0));

        // Overrun set wins over a simultaneous clear
        for (int i = 0; i < 16; i++) rx_send(8'h80 + 8'(i), lat);
        check("sw_full_count", 32'(rx_count), 32'(16));
        check("sw_overrun_pre", 32'(rx_overrun), 32'(0));
        ovr_clr   = 1'b1;
        u_rx_data = 8'hFF;
        u_valid   = 1'b1;
        tick();
        u_valid = 1'b0;
        ovr_clr = 1'b0;
        check("sw_ack", 32'(u_rd), 32'(1));
        check("sw_set_wins", 32'(rx_overrun), 32'(1));
        tick();
        check("sw_head_kept", 32'(cpu_din), 32'h80);
        check("sw_count_kept", 32'(rx_count), 32'(16));
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("sw_clear", 32'(rx_overrun), 32'(0));

        check("tx_busy_respected", 32'(busy_viol), 32'(0));
        check("tx_strobe_spacing", 32'(spacing_viol), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_fifo_bridge.md
# uart_fifo_bridge

Buffered bridge between the tiny1 memory-mapped UART ports and the `buart` serial core. It holds received bytes in an RX FIFO so the CPU can poll late without losing characters. It queues CPU writes in a TX FIFO so the CPU never stalls on `busy`. The CPU-facing side keeps the existing valid/din/ready/rd/wr semantics, so it drops in between the CPU's mmap decode and `buart` unchanged.

## Interface
- `DEPTH_LOG2`, 4: log2 of each FIFO depth. Both FIFOs are 2**DEPTH_LOG2 entries of 8 bits.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `cpu_din` out 8: head byte of RX FIFO (first-word-fall-through); 0 when RX is empty.
- `cpu_valid` out 1: RX FIFO not empty.
- `cpu_rd` in 1: pop RX head this cycle.
- `cpu_ready` out 1: TX FIFO not full.
- `cpu_wr` in 1: push `cpu_dout` into TX FIFO this cycle.
- `cpu_dout` in 8: byte to transmit.
- `ovr_clr` in 1: clear the sticky `rx_overrun` flag.
- `rx_overrun` out 1: sticky; set when a received byte was dropped because RX was full.
- `rx_count` out DEPTH_LOG2+1: RX occupancy, 0..2**DEPTH_LOG2.
- `u_rx_data` in 8: buart receive byte.
- `u_valid` in 1: buart has a byte; stays high until acknowledged.
- `u_rd` out 1: one-cycle acknowledge to buart.
- `u_busy` in 1: buart transmitter busy.
- `u_tx_data` out 8: byte to buart; only meaningful while `u_wr` is high.
- `u_wr` out 1: one-cycle transmit strobe to buart.

## Operation
- **RX FIFO storage and pointers**
  - Storage is a register array with DEPTH_LOG2-bit read and write pointers that wrap modulo depth.
  - Occupancy is a separate (DEPTH_LOG2+1)-bit counter.
- **RX state machine**
  - States are RX_IDLE and RX_ACK.
  - In RX_IDLE with `u_valid=1`:
    - pulse `u_rd` for one cycle and go to RX_ACK;
    - if RX is not full, write `u_rx_data` at the write pointer;
    - if RX is full, drop the byte and set `rx_overrun`.
  - RX_ACK always returns to RX_IDLE. It absorbs the one cycle `u_valid` takes to drop after `u_rd`.
- **RX pop**
  - `cpu_rd` with RX empty is ignored.
  - A push and a pop in the same cycle leave `rx_count` unchanged and advance both pointers.
- **TX FIFO**
  - Same structure as RX.
  - `cpu_wr` with TX full is ignored; the byte is lost and no flag is raised.
- **TX state machine**
  - States are TX_IDLE and TX_HOLD.
  - In TX_IDLE with TX not empty and `u_busy=0`:
    - drive `u_tx_data` with the head byte;
    - pulse `u_wr` for one cycle;
    - pop the head;
    - go to TX_HOLD.
  - TX_HOLD lasts one cycle and returns to TX_IDLE. It covers buart's one-cycle latency in raising `busy`.
- **Overrun flag**
  - `ovr_clr` clears `rx_overrun`.
  - If clear and set happen in the same cycle, set wins.
- **Outputs**
  - `u_rd` and `u_wr` are registered.
  - `cpu_valid`, `cpu_ready` and `rx_count` are derived from registered counts only.
  - `cpu_din` is a mux of the register array by the read pointer.

## Timing
- **Reset** (`rst=0` at a clock edge):
  - pointers and counts become 0; both state machines go idle;
  - `cpu_valid=0`, `cpu_ready=1`, `u_rd=0`, `u_wr=0`, `rx_overrun=0`, `rx_count=0`, `cpu_din=0`;
  - FIFO contents are discarded;
  - reset asserted mid-handshake aborts it, so a byte already acknowledged via `u_rd` is lost.
- **RX latency**
  - `u_valid` rises at edge N: `u_rd=1` during cycle N+1, data is written at that same edge.
  - `cpu_valid=1` and `cpu_din` show the byte from cycle N+1 onward.
- **RX rate**
  - Minimum spacing between acknowledges is 2 cycles.
  - At most one RX byte is accepted per 2 cycles.
- **CPU pop**
  - `cpu_rd` at edge M makes the next byte (or empty) visible from cycle M+1.
- **TX latency**
  - `cpu_wr` at edge M with the FIFO empty and the UART idle: `u_wr=1` in cycle M+1.
  - `cpu_ready` reflects the push from cycle M+1.
- **TX rate**
  - Back-to-back TX strobes are at least 2 cycles apart.
  - Thereafter they are gated by `u_busy`.
- **Full/empty boundaries**
  - RX full: `rx_count = 2**DEPTH_LOG2` and `cpu_valid=1`.
  - TX full: `cpu_ready=0`.
  - Pointer wrap from depth-1 to 0 is seamless.

## Test plan
- **RX single byte:** after reset, drive `u_valid=1`, `u_rx_data=0x41` and drop it after `u_rd`.
  - Expect exactly one `u_rd` pulse, then `cpu_valid=1`, `cpu_din=0x41`, `rx_count=1`.
  - After a `cpu_rd` pulse, expect `cpu_valid=0` and `rx_count=0`.
- **RX overflow (DEPTH_LOG2=4):** deliver 17 bytes 0x00..0x10 with no CPU reads.
  - Expect `rx_count=16` and `rx_overrun=1`.
  - Popping yields 0x00..0x0F in order; 0x10 never appears.
  - `ovr_clr` then drops `rx_overrun` to 0.
- **RX simultaneous push/pop at wrap:** with `rx_count=3` and both pointers near 15, pulse `cpu_rd` in the same cycle a new byte is written.
  - Expect `rx_count` to stay at 3 and FIFO order to be preserved across the wrap.
- **TX burst:** write 0x48, 0x49 back to back while the model's `u_busy` holds for 10 cycles after each `u_wr`.
  - Expect two `u_wr` pulses carrying 0x48 then 0x49, the second not before `u_busy` falls.
  - `cpu_ready` stays 1 throughout.
- **TX full:** hold `u_busy=1` and write 17 bytes.
  - Expect `cpu_ready=0` after the 16th write and the 17th write ignored.
  - After releasing `u_busy`, exactly 16 `u_wr` pulses occur.
- **Reset mid-operation:** assert `rst=0` for one cycle with RX holding 5 bytes and TX holding 3 bytes.
  - Expect `cpu_valid=0`, `cpu_ready=1`, `rx_count=0`, and no further `u_wr` pulses.
